id_regread_stage: RTL and testbench



---
 rtl/id_regread_stage.sv | 115 +++++++++++
 tb/tb_id_regread_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_regread_stage.sv
// Decode / register-read stage: steers the register-file read ports, bypasses
// same-cycle writeback, detects load-use hazards and fills the ID/EX register.
module id_regread_stage #(
    parameter int REG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [15:0]      if_instr,
    input  logic [15:0]      if_pc2,
    output logic             if_ready,
    output logic [3:0]       rf_src1,
    output logic [3:0]       rf_src2,
    input  logic [REG_W-1:0] rf_data1,
    input  logic [REG_W-1:0] rf_data2,
    input  logic             wb_we,
    input  logic [3:0]       wb_dst,
    input  logic [REG_W-1:0] wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [3:0]       ex_op,
    output logic [REG_W-1:0] ex_a,
    output logic [REG_W-1:0] ex_b,
    output logic [7:0]       ex_imm,
    output logic [3:0]       ex_dst,
    output logic             ex_we,
    output logic             ex_load,
    output logic [15:0]      ex_pc2,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_LLB  = 4'hA,
        OP_LHB  = 4'hB,
        OP_LINK = 4'hE
    } op_e;

    logic [3:0]       op, rd, rs, rt;
    logic             use1, use2, dec_we, hz, adv;
    logic [REG_W-1:0] opnd_a, opnd_b;

    assign op = if_instr[15:12];
    assign rd = if_instr[11:8];
    assign rs = if_instr[7:4];
    assign rt = if_instr[3:0];

    // R0 reads as zero regardless of the file; otherwise a matching writeback wins.
    function automatic logic [REG_W-1:0] pick(input logic [3:0] src,
                                              input logic [REG_W-1:0] rf,
                                              input logic we,
                                              input logic [3:0] dst,
                                              input logic [REG_W-1:0] data);
        if (src == '0)
            return '0;
        else if (we && dst == src)
            return data;
        else
            return rf;
    endfunction

    always_comb begin
        rf_src1 = (op == OP_LLB || op == OP_LHB) ? rd : rs;
        rf_src2 = (op == OP_SW) ? rd : rt;
        use1    = (op < 4'hC);
        use2    = (op <= 4'h7) || (op == OP_SW);
        dec_we  = ((op <= OP_LW) || (op == OP_LLB) || (op == OP_LHB) || (op == OP_LINK))
                  && (rd != '0);
        opnd_a  = pick(rf_src1, rf_data1, wb_we, wb_dst, wb_data);
        opnd_b  = pick(rf_src2, rf_data2, wb_we, wb_dst, wb_data);
        hz      = ex_valid && ex_load && (ex_dst != '0) && if_valid &&
                  ((use1 && ex_dst == rf_src1) || (use2 && ex_dst == rf_src2));
        adv      = !ex_valid || ex_ready;
        if_ready = flush || (adv && !hz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_dst    <= '0;
            ex_we     <= 1'b0;
            ex_load   <= 1'b0;
            ex_pc2    <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (hz) begin
                ex_valid <= 1'b0;
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ex_valid <= if_valid;
                if (if_valid) begin
                    ex_op   <= op;
                    ex_a    <= opnd_a;
                    ex_b    <= opnd_b;
                    ex_imm  <= if_instr[7:0];
                    ex_dst  <= rd;
                    ex_we   <= dec_we;
                    ex_load <= (op == OP_LW);
                    ex_pc2  <= if_pc2;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_regread_stage.sv
// Self-checking bench for id_regread_stage: directed scenarios plus randomized
// traffic compared against an opcode-table reference model.
module tb_id_regread_stage;

    localparam int REG_W   = 16;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;
    // Opcode property tables, bit n describes opcode n.
    localparam logic [15:0] WE_OPS = 16'h4DFF;
    localparam logic [15:0] P1_OPS = 16'h0FFF;
    localparam logic [15:0] P2_OPS = 16'h02FF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid, if_ready, wb_we, ex_valid, ex_ready, ex_we, ex_load, flush;
    logic [15:0]      if_instr, if_pc2, ex_pc2;
    logic [3:0]       rf_src1, rf_src2, wb_dst, ex_op, ex_dst;
    logic [REG_W-1:0] rf_data1, rf_data2, wb_data, ex_a, ex_b;
    logic [7:0]       ex_imm;
    logic [CNT_W-1:0] stall_cnt;

    logic [REG_W-1:0] regs [16];
    int unsigned      checks = 0;
    int unsigned      errors = 0;

    // reference state
    logic        mv, mwe, mload, last_acc;
    logic [3:0]  mop, mdst;
    logic [15:0] ma, mb, mpc2;
    logic [7:0]  mimm;
    int          mcnt;

    always #5 clk = ~clk;

    assign rf_data1 = regs[rf_src1];
    assign rf_data2 = regs[rf_src2];

    id_regread_stage #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc2(if_pc2), .if_ready(if_ready),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load), .ex_pc2(ex_pc2),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mv = 1'b0; mop = '0; ma = '0; mb = '0; mimm = '0; mdst = '0;
        mwe = 1'b0; mload = 1'b0; mpc2 = '0; mcnt = 0;
    endtask

    function automatic logic [15:0] operand(input logic [3:0] src);
        if (src == 4'd0) return 16'h0;
        if (wb_we && wb_dst == src) return wb_data;
        return regs[src];
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check state after edge.
    task automatic step();
        logic [3:0]  op, rd, s1, s2;
        logic        hz, adv, rdy;
        logic [15:0] a, b;
        @(negedge clk);
        op = if_instr[15:12];
        rd = if_instr[11:8];
        s1 = (op == 4'hA || op == 4'hB) ? rd : if_instr[7:4];
        s2 = (op == 4'h9) ? rd : if_instr[3:0];
        a  = operand(s1);
        b  = operand(s2);
        hz  = mv && mload && mdst != 0 && if_valid &&
              ((P1_OPS[op] && mdst == s1) || (P2_OPS[op] && mdst == s2));
        adv = !mv || ex_ready;
        rdy = flush || (adv && !hz);
        check("rf_src1", 32'(rf_src1), 32'(s1));
        check("rf_src2", 32'(rf_src2), 32'(s2));
        check("if_ready", 32'(if_ready), 32'(rdy));
        last_acc = if_valid && rdy;
        @(posedge clk);
        #1;
        if (flush) mv = 1'b0;
        else if (!adv) ;
        else if (hz) begin
            mv = 1'b0;
            if (mcnt < CNT_MAX) mcnt++;
        end else begin
            mv = if_valid;
            if (if_valid) begin
                mop = op; ma = a; mb = b; mimm = if_instr[7:0]; mdst = rd;
                mwe = WE_OPS[op] && rd != 0; mload = (op == 4'h8); mpc2 = if_pc2;
            end
        end
        check("ex_valid", 32'(ex_valid), 32'(mv));
        check("stall_cnt", 32'(stall_cnt), 32'(mcnt));
        if (mv) begin
            check("ex_op", 32'(ex_op), 32'(mop));
            check("ex_a", 32'(ex_a), 32'(ma));
            check("ex_b", 32'(ex_b), 32'(mb));
            check("ex_imm", 32'(ex_imm), 32'(mimm));
            check("ex_dst", 32'(ex_dst), 32'(mdst));
            check("ex_we", 32'(ex_we), 32'(mwe));
            check("ex_load", 32'(ex_load), 32'(mload));
            check("ex_pc2", 32'(ex_pc2), 32'(mpc2));
        end
    endtask

    task automatic put(input logic [15:0] instr);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc2   = 16'($urandom);
    endtask

    task automatic idle();
        if_valid = 1'b0;
        wb_we    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        regs[1] = 16'd5;
        regs[2] = 16'd7;
        rst_n = 1'b0; if_instr = '0; if_pc2 = '0; wb_dst = '0; wb_data = '0;
        idle();
        model_reset();
        #3;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_ex_op", 32'(ex_op), 32'd0);
        check("rst_ex_a", 32'(ex_a), 32'd0);
        #4 rst_n = 1'b1;

        // ADD R3,R1,R2
        put(16'h0312); step();
        check("add_a", 32'(ex_a), 32'd5);
        check("add_b", 32'(ex_b), 32'd7);
        check("add_dst", 32'(ex_dst), 32'd3);
        check("add_we", 32'(ex_we), 32'd1);

        // bypass: SUB R4,R1,R1 with writeback to R1
        put(16'h1411); wb_we = 1'b1; wb_dst = 4'd1; wb_data = 16'h00AA; step();
        check("byp_a", 32'(ex_a), 32'h00AA);
        check("byp_b", 32'(ex_b), 32'h00AA);
        put(16'h0400); wb_dst = 4'd0; step();
        check("r0_a", 32'(ex_a), 32'd0);
        check("r0_b", 32'(ex_b), 32'd0);
        wb_we = 1'b0;

        // load-use: LW R2 then ADD R5,R2,R3
        put(16'h8210); step();
        put(16'h0523); step();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        check("lu_held", 32'(last_acc), 32'd0);
        step();
        check("lu_issue_dst", 32'(ex_dst), 32'd5);
        // LW R0 then reader of R0: no bubble
        put(16'h8010); step();
        put(16'h0503); step();
        check("lw_r0_nostall", 32'(ex_valid), 32'd1);
        check("lw_r0_cnt", 32'(stall_cnt), 32'd1);

        // backpressure for three cycles, then resume
        put(16'h2612); step();
        ex_ready = 1'b0; put(16'h3723);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_dst_hold", 32'(ex_dst), 32'd6);
        end
        ex_ready = 1'b1; step();
        check("bp_resume_dst", 32'(ex_dst), 32'd7);

        // flush during a stalled load-use with backpressure
        put(16'h8210); step();
        ex_ready = 1'b0; put(16'h0523); flush = 1'b1; step();
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_cnt", 32'(stall_cnt), 32'd1);
        check("fl_accepted", 32'(last_acc), 32'd1);
        flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0; step();

        // steering: SW R6,R7,4 and LLB R9,0x3C
        put(16'h9674); step();
        check("sw_we", 32'(ex_we), 32'd0);
        put(16'hA93C); step();
        check("llb_imm", 32'(ex_imm), 32'h3C);
        check("llb_we", 32'(ex_we), 32'd1);

        // reset asserted in the middle of a load-use stall
        put(16'h8210); step();
        put(16'h0523);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ex_valid), 32'd0);
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        rst_n = 1'b1;
        step();
        check("post_rst_flow", 32'(ex_valid), 32'd1);

        // randomized traffic, small register range to force collisions
        idle();
        last_acc = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (last_acc || !if_valid) begin
                if_valid = ($urandom % 4) != 0;
                if_instr = {(($urandom % 3) == 0) ? 4'h8 : 4'($urandom),
                            4'($urandom % 4), 4'($urandom % 4), 4'($urandom % 4)};
                if_pc2   = 16'($urandom);
            end
            ex_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 16) == 0;
            wb_we    = $urandom % 2;
            wb_dst   = 4'($urandom % 4);
            wb_data  = 16'($urandom);
            if (($urandom % 8) == 0) regs[$urandom % 4] = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
